// File: rtl/pet_control_fsm_pkg.sv
// Shared types and constants for the virtual-pet control FSM: state encoding,
// action/status bit positions, bubble priority and the draw-request bundle.
package pet_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_START   = 4'd1,
        S_WAIT_GO = 4'd2,
        S_BG      = 4'd3,
        S_PET     = 4'd4,
        S_BUBBLE  = 4'd5,
        S_IDLE    = 4'd6,
        S_ACT     = 4'd7,
        S_GIVE    = 4'd8,
        S_END     = 4'd9,
        S_DEAD    = 4'd10
    } state_e;

    localparam int ACT_FOOD  = 0;
    localparam int ACT_BALL  = 1;
    localparam int ACT_PILLS = 2;
    localparam int ACT_BROOM = 3;
    localparam int ACT_FAID  = 4;
    localparam int N_ACT     = 5;

    // Status bits are ordered by bubble priority: a higher index wins.
    localparam int ST_BORED  = 0;
    localparam int ST_DIRTY  = 1;
    localparam int ST_HUNGRY = 2;
    localparam int ST_SICK   = 3;
    localparam int ST_DYING  = 4;
    localparam int N_ST      = 5;

    localparam logic [19:0] REFRESH_CYCLES_DEF = 20'd833333;

    typedef struct packed {
        logic             start;
        logic             bg;
        logic             pet;
        logic             zs;
        logic             fin;
        logic [N_ACT-1:0] item;
        logic [N_ST-1:0]  bubble;
    } draw_t;

    function automatic logic [N_ST-1:0] bubble_sel(input logic [N_ST-1:0] st);
        logic [N_ST-1:0] r;
        r = '0;
        for (int i = 0; i < N_ST; i++) begin
            if (st[i]) r = N_ST'(1) << i;
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [N_ACT-1:0] v);
        return (v != '0) && ((v & (v - N_ACT'(1))) == '0);
    endfunction

endpackage

// File: rtl/pet_control_fsm_if.sv
// Bundle of datapath flags, player inputs, renderer handshake and action pulses
// between the pet control FSM (master) and its surroundings (slave).
interface pet_control_fsm_if;
    import pet_ctrl_pkg::*;

    logic [N_ACT-1:0] sel;
    logic exec;
    logic draw_done;
    logic hungry, bored, sick, dirty, dying, deceased, sleeping;
    logic foodGiven, ballGiven, pillsGiven, broomGiven, firstAidGiven;
    logic draw_start, draw_bg, draw_pet, draw_zs, draw_end;
    logic draw_food, draw_ball, draw_pills, draw_broom, draw_firstAid;
    logic draw_hunger, draw_bored, draw_dirty, draw_sick, draw_dying;

    modport master (
        input  sel, exec, draw_done,
        input  hungry, bored, sick, dirty, dying, deceased, sleeping,
        output foodGiven, ballGiven, pillsGiven, broomGiven, firstAidGiven,
        output draw_start, draw_bg, draw_pet, draw_zs, draw_end,
        output draw_food, draw_ball, draw_pills, draw_broom, draw_firstAid,
        output draw_hunger, draw_bored, draw_dirty, draw_sick, draw_dying
    );

    modport slave (
        output sel, exec, draw_done,
        output hungry, bored, sick, dirty, dying, deceased, sleeping,
        input  foodGiven, ballGiven, pillsGiven, broomGiven, firstAidGiven,
        input  draw_start, draw_bg, draw_pet, draw_zs, draw_end,
        input  draw_food, draw_ball, draw_pills, draw_broom, draw_firstAid,
        input  draw_hunger, draw_bored, draw_dirty, draw_sick, draw_dying
    );

endinterface

// File: rtl/pet_control_fsm_key_edge_detect.sv
// Rising-edge detector for an already-synchronized key/level input.
module key_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) prev_q <= 1'b0;
        else         prev_q <= in_i;
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/pet_control_fsm.sv
// Virtual-pet control FSM: sequences renderer draw requests and issues
// single-cycle item pulses to the pet datapath.
module pet_control_fsm
    import pet_ctrl_pkg::*;
#(
    parameter int               TMR_W          = 20,
    parameter logic [TMR_W-1:0] REFRESH_CYCLES = TMR_W'(REFRESH_CYCLES_DEF)
) (
    input  logic               clk,
    input  logic               resetn,
    pet_control_fsm_if.master  bus
);

    localparam logic [TMR_W-1:0] TMR_LAST = REFRESH_CYCLES - TMR_W'(1);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [N_ACT-1:0]  act_q, act_d;
    logic [N_ST-1:0]   st_q, st_d;
    logic              slp_q, slp_d;
    draw_t             draw_q;
    logic [N_ACT-1:0]  give_q;

    logic              exec_rise;
    logic [N_ST-1:0]   st_now;
    logic              act_ok;
    logic              redraw;

    key_edge_detect u_exec_edge (
        .clk    (clk),
        .resetn (resetn),
        .in_i   (bus.exec),
        .rise_o (exec_rise)
    );

    always_comb begin
        st_now             = '0;
        st_now[ST_DYING]   = bus.dying;
        st_now[ST_SICK]    = bus.sick;
        st_now[ST_HUNGRY]  = bus.hungry;
        st_now[ST_DIRTY]   = bus.dirty;
        st_now[ST_BORED]   = bus.bored;
    end

    assign act_ok = exec_rise && is_onehot(bus.sel) && !bus.sleeping;
    assign redraw = (tmr_q == TMR_LAST) || (st_now != st_q) || (bus.sleeping != slp_q);

    // Outputs are registered from the next state so they match the state register.
    function automatic draw_t draw_decode(input state_e s, input logic [N_ACT-1:0] act,
                                          input logic [N_ST-1:0] st, input logic slp);
        draw_t d;
        d = '0;
        case (s)
            S_START:  d.start  = 1'b1;
            S_BG:     d.bg     = 1'b1;
            S_PET:    begin
                d.zs  = slp;
                d.pet = ~slp;
            end
            S_BUBBLE: d.bubble = bubble_sel(st);
            S_ACT:    d.item   = act;
            S_END:    d.fin    = 1'b1;
            default:  d        = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        act_d   = act_q;
        st_d    = st_q;
        slp_d   = slp_q;
        unique case (state_q)
            S_INIT:    state_d = S_START;
            S_START:   if (bus.draw_done) state_d = S_WAIT_GO;
            S_WAIT_GO: if (exec_rise) state_d = S_BG;
            S_BG: begin
                if (bus.draw_done) begin
                    slp_d   = bus.sleeping;
                    st_d    = st_now;
                    state_d = bus.deceased ? S_END : S_PET;
                end
            end
            S_PET: begin
                if (bus.draw_done) begin
                    if (bus.deceased)     state_d = S_END;
                    else if (st_q != '0)  state_d = S_BUBBLE;
                    else                  state_d = S_IDLE;
                end
            end
            S_BUBBLE:  if (bus.draw_done) state_d = S_IDLE;
            S_IDLE: begin
                if (bus.deceased) begin
                    state_d = S_END;
                end else if (act_ok) begin
                    act_d   = bus.sel;
                    state_d = S_ACT;
                end else if (redraw) begin
                    state_d = S_BG;
                end else begin
                    tmr_d   = tmr_q + TMR_W'(1);
                end
            end
            S_ACT:     if (bus.draw_done) state_d = bus.deceased ? S_END : S_GIVE;
            S_GIVE:    state_d = S_BG;
            S_END:     if (bus.draw_done) state_d = S_DEAD;
            S_DEAD:    state_d = S_DEAD;
            default:   state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_INIT;
            tmr_q   <= '0;
            act_q   <= '0;
            st_q    <= '0;
            slp_q   <= 1'b0;
            draw_q  <= '0;
            give_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            act_q   <= act_d;
            st_q    <= st_d;
            slp_q   <= slp_d;
            draw_q  <= draw_decode(state_d, act_d, st_d, slp_d);
            give_q  <= (state_d == S_GIVE) ? act_d : '0;
        end
    end

    assign bus.draw_start    = draw_q.start;
    assign bus.draw_bg       = draw_q.bg;
    assign bus.draw_pet      = draw_q.pet;
    assign bus.draw_zs       = draw_q.zs;
    assign bus.draw_end      = draw_q.fin;
    assign bus.draw_food     = draw_q.item[ACT_FOOD];
    assign bus.draw_ball     = draw_q.item[ACT_BALL];
    assign bus.draw_pills    = draw_q.item[ACT_PILLS];
    assign bus.draw_broom    = draw_q.item[ACT_BROOM];
    assign bus.draw_firstAid = draw_q.item[ACT_FAID];
    assign bus.draw_hunger   = draw_q.bubble[ST_HUNGRY];
    assign bus.draw_bored    = draw_q.bubble[ST_BORED];
    assign bus.draw_dirty    = draw_q.bubble[ST_DIRTY];
    assign bus.draw_sick     = draw_q.bubble[ST_SICK];
    assign bus.draw_dying    = draw_q.bubble[ST_DYING];
    assign bus.foodGiven     = give_q[ACT_FOOD];
    assign bus.ballGiven     = give_q[ACT_BALL];
    assign bus.pillsGiven    = give_q[ACT_PILLS];
    assign bus.broomGiven    = give_q[ACT_BROOM];
    assign bus.firstAidGiven = give_q[ACT_FAID];

endmodule

// File: tb/tb_pet_control_fsm.sv
// Vector-table bench for pet_control_fsm with a short refresh period; expected
// one-hot outputs are queued on drive and compared one clock later.
module tb_pet_control_fsm;

    // Output ids: bit position in the collected 20-bit output word
    localparam int O_N = -1, O_START = 0, O_BG = 1, O_PET = 2, O_ZS = 3, O_END = 4;
    localparam int O_FOOD = 5, O_BALL = 6, O_PILLS = 7;
    localparam int O_HUNGER = 10, O_SICK = 13, O_DYING = 14;
    localparam int O_GFOOD = 15, O_GPILLS = 17;

    // Flag word order: {deceased, sleeping, dying, sick, hungry, dirty, bored}
    localparam logic [6:0] F_DEC = 7'b1000000, F_SLP = 7'b0100000, F_DYING = 7'b0010000;
    localparam logic [6:0] F_SICK = 7'b0001000, F_HUNG = 7'b0000100;
    localparam logic [6:0] F_DIRTY = 7'b0000010, F_BORED = 7'b0000001;

    typedef struct {
        logic       rstn;
        logic [4:0] sel;
        logic       exec;
        logic       dd;
        logic [6:0] fl;
        int         exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    int   exp_q[$];

    always #5 clk = ~clk;

    pet_control_fsm_if bus();

    pet_control_fsm #(
        .TMR_W          (20),
        .REFRESH_CYCLES (20'd8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [19:0] oh(input int id);
        return (id < 0) ? 20'd0 : (20'd1 << id);
    endfunction

    function automatic logic [19:0] outs();
        return {bus.firstAidGiven, bus.broomGiven, bus.pillsGiven, bus.ballGiven, bus.foodGiven,
                bus.draw_dying, bus.draw_sick, bus.draw_dirty, bus.draw_bored, bus.draw_hunger,
                bus.draw_firstAid, bus.draw_broom, bus.draw_pills, bus.draw_ball, bus.draw_food,
                bus.draw_end, bus.draw_zs, bus.draw_pet, bus.draw_bg, bus.draw_start};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic void add(input logic r, input logic [4:0] s, input logic ex,
                                input logic dd, input logic [6:0] fl, input int exp);
        vec_t v;
        v.rstn = r; v.sel = s; v.exec = ex; v.dd = dd; v.fl = fl; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [6:0] fl);
        for (int k = 0; k < n; k++) add(1, 0, 0, 1, fl, O_N);
    endfunction

    function automatic void build_table();
        // Reset release with draw_done tied high, then first full redraw
        add(0, 0, 0, 1, 0, O_N);
        add(0, 0, 0, 1, 0, O_N);
        add(1, 0, 0, 1, 0, O_START);
        add(1, 0, 0, 1, 0, O_N);
        add(1, 0, 1, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        // Food with exec held for 10 cycles
        add(1, 5'b00001, 1, 0, 0, O_FOOD);
        add(1, 5'b00001, 1, 0, 0, O_FOOD);
        add(1, 5'b00001, 1, 1, 0, O_GFOOD);
        add(1, 5'b00001, 1, 0, 0, O_BG);
        add(1, 5'b00001, 1, 1, 0, O_PET);
        add(1, 5'b00001, 1, 1, 0, O_N);
        for (int k = 0; k < 4; k++) add(1, 5'b00001, 1, 1, 0, O_N);
        add(1, 5'b00001, 0, 1, 0, O_N);
        // Multi-bit select ignored, then refresh every 8 idle cycles
        add(1, 5'b00011, 1, 1, 0, O_N);
        add(1, 5'b00011, 0, 1, 0, O_N);
        add(1, 0, 0, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        add_n(7, 0);
        add(1, 0, 0, 1, 0, O_BG);
        // Sleeping latched at end of background draw
        add(1, 0, 0, 1, F_SLP, O_ZS);
        add(1, 0, 0, 1, F_SLP, O_N);
        add(1, 5'b00001, 1, 1, F_SLP, O_N);
        add(1, 5'b00001, 0, 1, F_SLP, O_N);
        add(1, 0, 0, 1, F_SLP, O_N);
        // Status change forces redraw; sick beats hungry
        add(1, 0, 0, 1, F_SLP | F_SICK | F_HUNG, O_BG);
        add(1, 0, 0, 1, F_SLP | F_SICK | F_HUNG, O_ZS);
        add(1, 0, 0, 1, F_SLP | F_SICK | F_HUNG, O_SICK);
        add(1, 0, 0, 0, F_SLP | F_SICK | F_HUNG, O_SICK);
        add(1, 0, 0, 1, F_SLP | F_SICK | F_HUNG, O_N);
        add(1, 0, 0, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        add(1, 0, 0, 1, F_DYING | F_DIRTY | F_BORED, O_BG);
        add(1, 0, 0, 1, F_DYING | F_DIRTY | F_BORED, O_PET);
        add(1, 0, 0, 1, F_DYING | F_DIRTY | F_BORED, O_DYING);
        add(1, 0, 0, 1, F_DYING | F_DIRTY | F_BORED, O_N);
        add(1, 0, 0, 1, F_HUNG | F_DIRTY | F_BORED, O_BG);
        add(1, 0, 0, 1, F_HUNG | F_DIRTY | F_BORED, O_PET);
        add(1, 0, 0, 1, F_HUNG | F_DIRTY | F_BORED, O_HUNGER);
        add(1, 0, 0, 1, F_HUNG | F_DIRTY | F_BORED, O_N);
        add(1, 0, 0, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        // Action and refresh expiry in the same cycle: action wins
        add_n(7, 0);
        add(1, 5'b00100, 1, 0, 0, O_PILLS);
        add(1, 5'b00100, 0, 1, 0, O_GPILLS);
        add(1, 5'b00100, 0, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        add_n(7, 0);
        add(1, 0, 0, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
        // Death during the pills animation: no pulse, end screen, then dead
        add(1, 5'b00100, 1, 0, 0, O_PILLS);
        add(1, 5'b00100, 0, 0, F_DEC, O_PILLS);
        add(1, 5'b00100, 0, 1, F_DEC, O_END);
        add(1, 0, 0, 0, F_DEC, O_END);
        add(1, 0, 0, 1, F_DEC, O_N);
        add(1, 5'b00001, 1, 1, F_DEC, O_N);
        add(1, 5'b00001, 0, 1, 0, O_N);
        add(1, 5'b00001, 1, 1, 0, O_N);
        // Reset in the middle of the end-screen draw
        add(0, 0, 0, 1, F_DEC, O_N);
        add(1, 0, 0, 1, F_DEC, O_START);
        add(1, 0, 0, 1, F_DEC, O_N);
        add(1, 0, 1, 1, F_DEC, O_BG);
        add(1, 0, 0, 1, F_DEC, O_END);
        add(1, 0, 0, 0, F_DEC, O_END);
        add(0, 0, 0, 1, F_DEC, O_N);
        add(0, 0, 0, 0, 0, O_N);
        add(1, 0, 0, 1, 0, O_START);
        add(1, 0, 0, 1, 0, O_N);
        add(1, 0, 1, 1, 0, O_BG);
        add(1, 0, 0, 1, 0, O_PET);
        add(1, 0, 0, 1, 0, O_N);
    endfunction

    initial begin
        int e;
        int seen;
        int wait_n;
        resetn = 1'b0;
        bus.sel = '0; bus.exec = 1'b0; bus.draw_done = 1'b0;
        {bus.deceased, bus.sleeping, bus.dying, bus.sick, bus.hungry, bus.dirty, bus.bored} = '0;
        build_table();

        foreach (vecs[i]) begin
            @(negedge clk);
            resetn        = vecs[i].rstn;
            bus.sel       = vecs[i].sel;
            bus.exec      = vecs[i].exec;
            bus.draw_done = vecs[i].dd;
            {bus.deceased, bus.sleeping, bus.dying, bus.sick, bus.hungry, bus.dirty, bus.bored} = vecs[i].fl;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(oh(e)));
        end

        // Ball draw held while renderer is busy; exec pulse mid-draw is dropped
        @(negedge clk);
        bus.sel = 5'b00010; bus.exec = 1'b1; bus.draw_done = 1'b0;
        @(posedge clk); #1;
        check("ball_req", 32'(outs()), 32'(oh(O_BALL)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.exec = (k == 1);
            @(posedge clk); #1;
            check("ball_hold", 32'(outs()), 32'(oh(O_BALL)));
        end
        @(negedge clk);
        bus.draw_done = 1'b1;
        seen = 0;
        wait_n = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(posedge clk); #1;
            wait_n++;
            if (bus.ballGiven) seen = 1;
        end
        check("ball_given_seen", seen, 1);
        check("ball_given_latency", wait_n, 1);
        @(posedge clk); #1;
        check("ball_given_width", 32'(outs()), 32'(oh(O_BG)));
        @(posedge clk); #1;
        check("ball_pet", 32'(outs()), 32'(oh(O_PET)));
        @(posedge clk); #1;
        check("ball_idle", 32'(outs()), 32'(oh(O_N)));

        // Death noticed while idle
        @(negedge clk);
        bus.deceased = 1'b1; bus.draw_done = 1'b0;
        @(posedge clk); #1;
        check("idle_death", 32'(outs()), 32'(oh(O_END)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pet_control_fsm.md
Name: pet_control_fsm

Overview:
- Control FSM for the virtual-pet game; the counterpart of the pet datapath.
- Consumes the datapath status flags and the player's switch/key inputs.
- Issues one-hot draw_* requests to the VGA sprite renderer, waiting for its completion handshake between requests.
- Issues single-cycle *Given pulses back to the datapath once an item animation finishes.

Parameters:
- REFRESH_CYCLES, 20'd833333: idle cycles before a forced redraw (60 Hz at 50 MHz).
- TMR_W, 20: width of the refresh counter.

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  synchronous, active-low reset
- sel  in  5  item select: [0] food, [1] ball, [2] pills, [3] broom, [4] first aid (SW[4:0])
- exec  in  1  execute request, active-high, already synchronized (inverted KEY[2])
- draw_done  in  1  renderer completion pulse for the current draw request
- hungry, bored, sick, dirty, dying, deceased, sleeping  in  1 each  datapath status flags
- foodGiven, ballGiven, pillsGiven, broomGiven, firstAidGiven  out  1 each  single-cycle action pulses to the datapath
- draw_start, draw_bg, draw_pet, draw_zs, draw_end  out  1 each  screen/pet draw requests
- draw_food, draw_ball, draw_pills, draw_broom, draw_firstAid  out  1 each  item animation requests
- draw_hunger, draw_bored, draw_dirty, draw_sick, draw_dying  out  1 each  status bubble requests

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state <= S_INIT; all outputs 0.
  - Refresh timer, latched action and latched status vector cleared.
  - Reset wins over every other event, including mid-draw or mid-pulse.
- Outputs are Moore decodes of the state register.
  - At most one draw_* is high in any cycle.
  - A draw_* is held high for the whole draw state until draw_done is sampled high.
  - draw_done high in the first cycle of a draw state is legal: the state exits next cycle, so a draw is at least 1 cycle.
  - draw_done outside draw states is ignored.
- exec is edge-detected internally (prev register): exec_rise = exec & ~exec_q. Level-held exec produces one event.
- States and transitions:
  - S_INIT -> S_START unconditionally. draw_start is first high in the 2nd cycle after reset release.
  - S_START (draw_start): on draw_done -> S_WAIT_GO.
  - S_WAIT_GO (no outputs): on exec_rise -> S_BG.
  - S_BG (draw_bg): on draw_done, latch sleeping into slp_l and the status vector {dying,sick,hungry,dirty,bored} into st_l. Then go to S_END if deceased, else S_PET.
  - S_PET (draw_zs if slp_l, else draw_pet): on draw_done go to S_END if deceased, else S_BUBBLE if st_l≠0, else S_IDLE.
  - S_BUBBLE: draws exactly one bubble, fixed priority dying > sick > hungry > dirty > bored. On draw_done -> S_IDLE.
  - S_IDLE: refresh timer counts up each cycle. Exits, first match wins:
    - deceased -> S_END.
    - exec_rise with sel one-hot and sleeping=0 -> latch sel into act_l -> S_ACT.
    - Timer == REFRESH_CYCLES-1, or the current status vector/sleeping differs from the latched copies -> S_BG.
    - Timer clears on every exit from S_IDLE.
  - S_ACT: asserts the draw_* matching act_l. On draw_done go to S_END if deceased, else S_GIVE.
  - S_GIVE: pulses the *Given matching act_l for exactly 1 cycle -> S_BG.
  - S_END (draw_end): on draw_done -> S_DEAD.
  - S_DEAD: all outputs 0. Exits only on reset.
- Boundary rules:
  - exec_rise with sel=0, multiple bits set, or sleeping=1: ignored, state unchanged, timer keeps counting.
  - exec_rise outside S_IDLE and S_WAIT_GO: dropped, never queued.
  - sel changing after the latch does not affect act_l.
  - exec_rise and refresh expiry in the same cycle: the action wins.
  - deceased rising during S_ACT: draw completes, no *Given pulse, then S_END.
  - Refresh timer never wraps; it is compared at REFRESH_CYCLES-1 and cleared on exit.

Decomposition:
- Package pet_ctrl_pkg holds:
  - state enum/localparams (S_INIT…S_DEAD, 4-bit encoding);
  - action index constants ACT_FOOD=0 … ACT_FAID=4;
  - bubble priority order;
  - REFRESH_CYCLES default.
- One sub-module, key_edge_detect: clk/resetn/in -> rise; reused for future key inputs.

Test Plan:
- Reset release, draw_done tied 1 -> draw_start high in cycle 2; exec_rise -> draw_bg, draw_pet, then S_IDLE with no bubble (all status 0).
- In S_IDLE, sel=5'b00001, exec held high for 10 cycles -> draw_food until draw_done, then foodGiven high for exactly 1 cycle, then draw_bg; only one action despite the held exec.
- sel=5'b00011 or sleeping=1 with exec pulse -> no draw_* item request and no *Given; FSM stays in S_IDLE.
- With REFRESH_CYCLES=8 and status static -> draw_bg reasserted every 8 idle cycles. Set sick=1 and hungry=1 -> redraw next cycle, and draw_sick is the only bubble.
- deceased=1 asserted mid-S_ACT (pills) -> no pillsGiven; draw_end follows, then all outputs 0 until reset. resetn=0 mid-S_END -> S_INIT, all outputs 0.
- sleeping=1 at the end of S_BG -> draw_zs instead of draw_pet. exec_rise and timer expiry in the same cycle -> action path taken and timer cleared.
